// File: rtl/instr_mem_pkg.sv
// Shared defaults and state encoding for the loadable instruction memory.
package instr_mem_pkg;

  localparam int unsigned WORD_LEN_DEF = 32;
  localparam int unsigned CELL_W_DEF   = 8;
  localparam int unsigned DEPTH_DEF    = 256;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_RUN   = 2'd1,
    ST_LOAD  = 2'd2
  } state_e;

endpackage

// File: rtl/instr_byte_ram.sv
// Cell-organised program store: one write port (BPW-cell clear or single cell)
// and a combinational BPW-cell read port that wraps modulo DEPTH.
module instr_byte_ram #(
  parameter int unsigned CELL_W = 8,
  parameter int unsigned BPW    = 4,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned AW     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic                  wr_clear,
  input  logic [AW-1:0]         wr_addr,
  input  logic [CELL_W-1:0]     wr_data,
  input  logic [AW-1:0]         rd_addr,
  output logic [BPW*CELL_W-1:0] rd_data
);

  logic [CELL_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  cell_we;

  // Clear touches BPW consecutive cells; the AW-bit sum wraps naturally.
  always_comb begin
    cell_we = '0;
    if (wr_en) begin
      if (wr_clear) begin
        for (int unsigned k = 0; k < BPW; k++) begin
          cell_we[wr_addr + AW'(k)] = 1'b1;
        end
      end else begin
        cell_we[wr_addr] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (cell_we[i]) begin
        mem_q[i] <= wr_clear ? '0 : wr_data;
      end
    end
  end

  // Lowest-addressed cell lands in the most significant bits.
  for (genvar k = 0; k < BPW; k++) begin : g_rd
    assign rd_data[(BPW-1-k)*CELL_W +: CELL_W] = mem_q[rd_addr + AW'(k)];
  end

endmodule

// File: rtl/instr_mem_loadable.sv
// Instruction memory that self-clears after reset, accepts a streamed program
// load from cell 0, and serves registered word fetches while running.
module instr_mem_loadable
  import instr_mem_pkg::*;
#(
  parameter int unsigned WORD_LEN = WORD_LEN_DEF,
  parameter int unsigned CELL_W   = CELL_W_DEF,
  parameter int unsigned DEPTH    = DEPTH_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_start,
  input  logic                load_valid,
  input  logic [CELL_W-1:0]   load_data,
  input  logic                load_last,
  output logic                load_ready,
  output logic                load_done,
  input  logic                fetch_req,
  input  logic [WORD_LEN-1:0] addr,
  output logic [WORD_LEN-1:0] instruction,
  output logic                instr_valid,
  output logic                misaligned,
  output logic                busy
);

  localparam int unsigned BPW = WORD_LEN / CELL_W;
  localparam int unsigned AW  = $clog2(DEPTH);

  localparam logic [AW-1:0] PTR_STEP   = AW'(BPW);
  localparam logic [AW-1:0] LAST_WORD  = AW'(DEPTH - BPW);
  localparam logic [AW-1:0] LAST_CELL  = AW'(DEPTH - 1);
  localparam logic [AW-1:0] ALIGN_MASK = AW'(BPW - 1);

  state_e              state_q, state_d;
  logic [AW-1:0]       ptr_q, ptr_d;
  logic [WORD_LEN-1:0] instr_q, instr_d;
  logic                mis_q, mis_d;
  logic                valid_q, valid_d;
  logic                done_q, done_d;

  logic                wr_en;
  logic                wr_clear;
  logic [AW-1:0]       fetch_idx;
  logic [WORD_LEN-1:0] rd_data;

  assign fetch_idx = addr[AW-1:0];

  if (WORD_LEN > AW) begin : g_addr_hi
    logic addr_hi_unused;
    assign addr_hi_unused = ^addr[WORD_LEN-1:AW];
  end

  instr_byte_ram #(
    .CELL_W (CELL_W),
    .BPW    (BPW),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk      (clk),
    .wr_en    (wr_en),
    .wr_clear (wr_clear),
    .wr_addr  (ptr_q),
    .wr_data  (load_data),
    .rd_addr  (fetch_idx),
    .rd_data  (rd_data)
  );

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    instr_d  = instr_q;
    mis_d    = mis_q;
    valid_d  = 1'b0;
    done_d   = 1'b0;
    wr_en    = 1'b0;
    wr_clear = 1'b0;

    case (state_q)
      ST_CLEAR: begin
        wr_en    = 1'b1;
        wr_clear = 1'b1;
        if (ptr_q == LAST_WORD) begin
          state_d = ST_RUN;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + PTR_STEP;
        end
      end

      ST_RUN: begin
        // The read happens before any load write, so a coincident
        // load_start still sees the old program.
        if (fetch_req) begin
          valid_d = 1'b1;
          instr_d = rd_data;
          mis_d   = |(fetch_idx & ALIGN_MASK);
        end
        if (load_start) begin
          state_d = ST_LOAD;
          ptr_d   = '0;
        end
      end

      ST_LOAD: begin
        if (load_valid) begin
          wr_en = 1'b1;
          ptr_d = ptr_q + AW'(1);
          if (load_last || (ptr_q == LAST_CELL)) begin
            state_d = ST_RUN;
            ptr_d   = '0;
            done_d  = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
      instr_q <= '0;
      mis_q   <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      instr_q <= instr_d;
      mis_q   <= mis_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign instruction = instr_q;
  assign misaligned  = mis_q;
  assign instr_valid = valid_q;
  assign load_done   = done_q;
  assign load_ready  = (state_q == ST_LOAD);
  assign busy        = (state_q != ST_RUN);

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Directed bench for instr_mem_loadable with a fetch-expectation scoreboard.
module tb_instr_mem_loadable;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_start = 1'b0;
  logic        load_valid = 1'b0;
  logic [7:0]  load_data = '0;
  logic        load_last = 1'b0;
  logic        load_ready;
  logic        load_done;
  logic        fetch_req = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        misaligned;
  logic        busy;

  int npass  = 0;
  int ntotal = 0;

  typedef struct {
    logic        v;
    logic [31:0] ins;
    logic        mis;
    string       tag;
  } exp_t;

  exp_t exp_q[$];

  instr_mem_loadable #(
    .WORD_LEN (32),
    .CELL_W   (8),
    .DEPTH    (256)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .load_start  (load_start),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_last   (load_last),
    .load_ready  (load_ready),
    .load_done   (load_done),
    .fetch_req   (fetch_req),
    .addr        (addr),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .misaligned  (misaligned),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({e.tag, ".valid"}, 32'(instr_valid), 32'(e.v));
      chk({e.tag, ".instr"}, instruction, e.ins);
      chk({e.tag, ".mis"}, 32'(misaligned), 32'(e.mis));
    end
  endtask

  task automatic fetch(input logic [31:0] a, input logic v, input logic [31:0] ins,
                       input logic mis, input string tag);
    fetch_req = 1'b1;
    addr      = a;
    exp_q.push_back('{v: v, ins: ins, mis: mis, tag: tag});
    tick();
    fetch_req = 1'b0;
    addr      = '0;
  endtask

  task automatic load_cells(input logic [7:0] cells[$], input bit use_last, input string tag);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    chk({tag, ".ready"}, 32'(load_ready), 32'd1);
    for (int i = 0; i < cells.size(); i++) begin
      load_valid = 1'b1;
      load_data  = cells[i];
      load_last  = use_last && (i == cells.size() - 1);
      tick();
      if (i == cells.size() - 1) begin
        chk({tag, ".done"}, 32'(load_done), 32'd1);
        chk({tag, ".busy_end"}, 32'(busy), 32'd0);
      end else begin
        chk({tag, ".done_early"}, 32'(load_done), 32'd0);
      end
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    tick();
    chk({tag, ".done_pulse"}, 32'(load_done), 32'd0);
  endtask

  initial begin
    logic [7:0] prog[$];
    int cnt;

    // Reset and the post-reset clear sweep.
    tick();
    tick();
    chk("rst.busy", 32'(busy), 32'd1);
    chk("rst.ready", 32'(load_ready), 32'd0);
    chk("rst.valid", 32'(instr_valid), 32'd0);
    chk("rst.instr", instruction, 32'd0);
    chk("rst.mis", 32'(misaligned), 32'd0);
    chk("rst.done", 32'(load_done), 32'd0);
    rst = 1'b0;
    cnt = 0;
    while (busy && cnt < 200) begin
      tick();
      cnt++;
    end
    chk("clear.cycles", 32'(cnt), 32'd64);
    chk("run.ready", 32'(load_ready), 32'd0);
    fetch(32'd8, 1'b1, 32'h0000_0000, 1'b0, "f8_zero");

    // Short program terminated by load_last.
    prog = '{8'h0C, 8'h41, 8'h18, 8'h00};
    load_cells(prog, 1'b1, "load4");
    fetch(32'd0, 1'b1, 32'h0C41_1800, 1'b0, "f0");
    fetch(32'd2, 1'b1, 32'h1800_0000, 1'b1, "f2");
    fetch(32'd1, 1'b1, 32'h4118_0000, 1'b1, "f1");
    fetch(32'h104, 1'b1, 32'h0000_0000, 1'b0, "f104");

    // Coincident load_start + fetch serves old data; fetch in LOAD is dropped.
    load_start = 1'b1;
    fetch(32'd0, 1'b1, 32'h0C41_1800, 1'b0, "coinc");
    load_start = 1'b0;
    chk("coinc.ready", 32'(load_ready), 32'd1);
    fetch(32'd0, 1'b0, 32'h0C41_1800, 1'b0, "f_in_load");
    load_valid = 1'b1;
    load_data  = 8'hAA;
    tick();
    load_data  = 8'hBB;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    load_data  = 8'hCC;
    load_last  = 1'b1;
    tick();
    chk("reload.done", 32'(load_done), 32'd1);
    load_valid = 1'b0;
    load_last  = 1'b0;
    tick();
    chk("reload.done_pulse", 32'(load_done), 32'd0);
    fetch(32'd0, 1'b1, 32'hAABB_CC00, 1'b0, "reload.f0");

    // Full-depth load ends at the last cell without load_last.
    prog.delete();
    for (int i = 0; i < 256; i++) prog.push_back(8'(i));
    load_cells(prog, 1'b0, "load256");
    fetch(32'd254, 1'b1, 32'hFEFF_0001, 1'b1, "f254");
    fetch(32'h3FC, 1'b1, 32'hFCFD_FEFF, 1'b0, "f3fc");
    load_valid = 1'b1;
    load_data  = 8'h55;
    tick();
    load_valid = 1'b0;
    chk("run.ready_valid", 32'(load_ready), 32'd0);
    fetch(32'd0, 1'b1, 32'h0001_0203, 1'b0, "f0_after_ignored");

    // Reset mid-load aborts and re-clears.
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    load_valid = 1'b1;
    load_data  = 8'h11;
    tick();
    load_data  = 8'h22;
    tick();
    load_valid = 1'b0;
    rst = 1'b1;
    tick();
    chk("abort.done", 32'(load_done), 32'd0);
    chk("abort.busy", 32'(busy), 32'd1);
    chk("abort.ready", 32'(load_ready), 32'd0);
    chk("abort.instr", instruction, 32'd0);
    rst = 1'b0;
    fetch(32'd0, 1'b0, 32'h0000_0000, 1'b0, "f_in_clear");
    cnt = 1;
    while (busy && cnt < 200) begin
      tick();
      cnt++;
    end
    chk("abort.clear_cycles", 32'(cnt), 32'd64);
    chk("abort.no_done", 32'(load_done), 32'd0);
    fetch(32'd0, 1'b1, 32'h0000_0000, 1'b0, "abort.f0");
    fetch(32'd4, 1'b1, 32'h0000_0000, 1'b0, "abort.f4");
    chk("sb.empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
